// File: rtl/usb_pkg.sv
// Shared USB constants: token PIDs, frame timing and the 5-bit token CRC.
package usb_pkg;

    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;

    localparam int FULL_SPEED_FRAME_CYCLES = 48000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_PID,
        ST_B1,
        ST_B2
    } sof_state_e;

    // x^5+x^2+1, seeded with ones, field consumed LSB first, residue inverted.
    function automatic logic [4:0] crc5(input logic [10:0] field);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (field[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else                 c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

endpackage

// File: rtl/usb_sof_gen_if.sv
// Byte valid/ready stream carrying token bytes toward the host transmitter.
interface usb_sof_gen_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/usb_sof_gen.sv
// Host-side SOF generator: frame timer, 11-bit frame counter and a token FSM
// that emits PID, frame[7:0], {crc5, frame[10:8]} on a byte stream.
module usb_sof_gen
    import usb_pkg::*;
#(
    parameter int         FRAME_CYCLES = FULL_SPEED_FRAME_CYCLES,
    parameter logic [7:0] SOF_PID      = PID_SOF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 tx_busy,
    usb_sof_gen_if.master        tx,
    output logic                 frame_tick,
    output logic [10:0]          frame_index,
    output logic                 sof_sent,
    output logic                 sof_missed
);

    localparam int              TW        = $clog2(FRAME_CYCLES);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(FRAME_CYCLES - 1);

    sof_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          frame_tick_q, frame_tick_d;
    logic [10:0]   frame_index_q, frame_index_d;
    logic [10:0]   sof_frame_q, sof_frame_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic          sof_sent_q, sof_sent_d;
    logic          sof_missed_q, sof_missed_d;
    logic          accept;
    logic          start;

    assign accept = tx_valid_q && tx.tx_ready;

    always_comb begin
        timer_d       = timer_q;
        frame_tick_d  = 1'b0;
        frame_index_d = frame_index_q;
        state_d       = state_q;
        pending_d     = pending_q;
        sof_frame_d   = sof_frame_q;
        sof_sent_d    = 1'b0;
        sof_missed_d  = 1'b0;
        tx_data_d     = 8'h00;
        tx_valid_d    = 1'b0;
        tx_last_d     = 1'b0;

        if (!enable) begin
            timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
            timer_d      = '0;
            frame_tick_d = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (frame_tick_q) frame_index_d = frame_index_q + 11'd1;

        case (state_q)
            ST_IDLE:     if (pending_q) state_d = tx_busy ? ST_WAIT_BUS : ST_PID;
            ST_WAIT_BUS: if (!pending_q) state_d = ST_IDLE;
                         else if (!tx_busy) state_d = ST_PID;
            ST_PID:      if (accept) state_d = ST_B1;
            ST_B1:       if (accept) state_d = ST_B2;
            ST_B2: begin
                if (accept) begin
                    state_d    = ST_IDLE;
                    sof_sent_d = 1'b1;
                end
            end
            default:     state_d = ST_IDLE;
        endcase

        start = (state_q == ST_IDLE || state_q == ST_WAIT_BUS) && state_d == ST_PID;
        if (start) begin
            sof_frame_d = frame_index_q;
            pending_d   = 1'b0;
        end
        // A tick that lands on an unstarted SOF supersedes it; the newer frame wins.
        if (frame_tick_q) begin
            pending_d    = 1'b1;
            sof_missed_d = pending_q && !start;
        end
        if (!enable) pending_d = 1'b0;

        // Outputs follow the next state so a byte is held until accepted.
        tx_valid_d = (state_d == ST_PID) || (state_d == ST_B1) || (state_d == ST_B2);
        tx_last_d  = (state_d == ST_B2);
        case (state_d)
            ST_PID:  tx_data_d = SOF_PID;
            ST_B1:   tx_data_d = sof_frame_q[7:0];
            ST_B2:   tx_data_d = {crc5(sof_frame_q), sof_frame_q[10:8]};
            default: tx_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            frame_tick_q  <= 1'b0;
            frame_index_q <= 11'd0;
            sof_frame_q   <= 11'd0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            tx_last_q     <= 1'b0;
            sof_sent_q    <= 1'b0;
            sof_missed_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            frame_tick_q  <= frame_tick_d;
            frame_index_q <= frame_index_d;
            sof_frame_q   <= sof_frame_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_last_q     <= tx_last_d;
            sof_sent_q    <= sof_sent_d;
            sof_missed_q  <= sof_missed_d;
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_last  = tx_last_q;
    assign frame_tick  = frame_tick_q;
    assign frame_index = frame_index_q;
    assign sof_sent    = sof_sent_q;
    assign sof_missed  = sof_missed_q;

endmodule
